// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite register bank.
package sprite_pkg;

  localparam int NUM_ENTRIES = 20;
  localparam int ENTRY_W     = 24;
  localparam int OUT_W       = 512;
  localparam int ADDR_W      = 5;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd20;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd21;

  // Entry layout as seen by the display; this block stores it verbatim.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] id;
  } sprite_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_e;

endpackage

// File: rtl/sprite_reg_bank.sv
// Avalon-MM sprite register bank: CPU fills a shadow set, which is copied
// atomically into the active set (driving the display) on a frame boundary.
module sprite_reg_bank
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              frame_start,
  output logic [OUT_W-1:0]  gl_output,
  output logic              gl_write
);

  localparam int USED_W = NUM_ENTRIES * ENTRY_W;

  sprite_entry_t     shadow_q [NUM_ENTRIES];
  sprite_entry_t     active_q [NUM_ENTRIES];
  commit_state_e     state_q, state_d;
  logic              auto_commit_q, auto_commit_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              gl_write_q;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       rd_mux;

  logic              wr_en;
  logic              rd_en;
  logic              ctrl_wr;
  logic              commit_req;
  logic              commit_fire;
  logic              pending;
  logic [NUM_ENTRIES-1:0] entry_we;

  assign wr_en      = chipselect & write;
  assign rd_en      = chipselect & read;
  assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
  assign commit_req = ctrl_wr && writedata[0];
  assign pending    = (state_q == ARMED);

  // A same-cycle request counts, so a request coinciding with frame_start
  // commits immediately instead of waiting a whole frame.
  assign commit_fire = frame_start && (pending || commit_req || auto_commit_q);

  // Per-entry write decode and packing of the active set onto the output bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign entry_we[gi] = wr_en && (address == ADDR_W'(gi));
      assign gl_output[gi*ENTRY_W +: ENTRY_W] = active_q[gi];
    end
  endgenerate

  assign gl_output[OUT_W-1:USED_W] = '0;

  // Commit FSM next state: a commit always returns to IDLE; extra requests
  // while ARMED are absorbed.
  always_comb begin
    state_d = state_q;
    if (commit_fire) begin
      state_d = IDLE;
    end else if (commit_req) begin
      state_d = ARMED;
    end
  end

  // Control/status next-state values.
  always_comb begin
    auto_commit_d = auto_commit_q;
    if (ctrl_wr) begin
      auto_commit_d = writedata[1];
    end
    frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Read mux from current (pre-write) register state; readdata holds otherwise.
  always_comb begin
    rd_mux = '0;
    if (address < ADDR_CTRL) begin
      rd_mux = {8'h00, shadow_q[address]};
    end else if (address == ADDR_CTRL) begin
      rd_mux = {30'h0, auto_commit_q, pending};
    end else if (address == ADDR_STATUS) begin
      rd_mux = {15'h0, pending, frame_cnt_q};
    end
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

  // Control registers, FSM state, frame counter and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      auto_commit_q <= 1'b0;
      frame_cnt_q   <= '0;
      gl_write_q    <= 1'b0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      auto_commit_q <= auto_commit_d;
      frame_cnt_q   <= frame_cnt_d;
      gl_write_q    <= commit_fire;
      readdata_q    <= readdata_d;
    end
  end

  // Shadow and active sets; active copies the shadow value from before any
  // write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (entry_we[i]) begin
          shadow_q[i] <= sprite_entry_t'(writedata[ENTRY_W-1:0]);
        end
        if (commit_fire) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign gl_write = gl_write_q;

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Scoreboard bench for sprite_reg_bank with a behavioural model of the
// shadow/active sets, commit request and frame counter.
module tb_sprite_reg_bank;
  import sprite_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [4:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              frame_start = 1'b0;
  logic [511:0]      gl_output;
  logic              gl_write;

  always #10 clk = ~clk;

  sprite_reg_bank dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata),
    .readdata(readdata), .frame_start(frame_start),
    .gl_output(gl_output), .gl_write(gl_write)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; string name; } rd_exp_t;
  typedef struct { int due; logic [511:0] data; } gl_exp_t;
  rd_exp_t rd_q[$];
  gl_exp_t gl_q[$];

  // Behavioural model
  logic [23:0] m_shadow [20];
  logic [23:0] m_active [20];
  bit          m_armed;
  bit          m_auto;
  logic [15:0] m_fcnt;

  function automatic logic [511:0] model_out();
    logic [511:0] v = '0;
    for (int i = 0; i < 20; i++) v[i*24 +: 24] = m_active[i];
    return v;
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] a);
    if (a < 5'd20) return {8'h00, m_shadow[a]};
    if (a == 5'd20) return {30'h0, m_auto, m_armed};
    if (a == 5'd21) return {15'h0, m_armed, m_fcnt};
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 20; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_armed = 0;
    m_auto  = 0;
    m_fcnt  = '0;
  endtask

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected responses when the DUT presents them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        check(rd_q[0].name, {480'h0, readdata}, {480'h0, rd_q[0].data});
        void'(rd_q.pop_front());
      end
      if (gl_q.size() > 0 && gl_q[0].due == cyc) begin
        check("gl_write_pulse", {511'h0, gl_write}, 512'h1);
        check("gl_output_commit", gl_output, gl_q[0].data);
        void'(gl_q.pop_front());
      end else begin
        check("gl_write_idle", {511'h0, gl_write}, 512'h0);
      end
      check("gl_output_hold", gl_output, model_out());
    end
  end

  // One bus cycle; model is advanced at the clock edge the DUT samples.
  task automatic op(bit cs, bit wr, bit rd, logic [4:0] a, logic [31:0] wd,
                    bit fs, string name);
    int due;
    bit creq, commit;
    chipselect = cs; write = wr; read = rd; address = a;
    writedata = wd; frame_start = fs;
    due = cyc + 1;
    if (cs && rd) rd_q.push_back('{due, model_read(a), name});
    creq   = cs && wr && (a == 5'd20) && wd[0];
    commit = fs && (m_armed || creq || m_auto);
    @(posedge clk);
    if (commit) begin
      for (int i = 0; i < 20; i++) m_active[i] = m_shadow[i];
      gl_q.push_back('{due, model_out()});
    end
    if (cs && wr && a < 5'd20) m_shadow[a] = wd[23:0];
    if (cs && wr && a == 5'd20) m_auto = wd[1];
    m_armed = commit ? 1'b0 : (creq ? 1'b1 : m_armed);
    if (fs) m_fcnt = m_fcnt + 16'd1;
    #1;
    chipselect = 0; write = 0; read = 0; frame_start = 0;
  endtask

  task automatic wr_op(logic [4:0] a, logic [31:0] d, bit fs);
    op(1, 1, 0, a, d, fs, "write");
  endtask

  task automatic rd_op(logic [4:0] a, string name);
    op(1, 0, 1, a, 32'h0, 0, name);
  endtask

  task automatic fs_op();
    op(0, 0, 0, 5'd0, 32'h0, 1, "frame");
  endtask

  task automatic idle_op();
    op(0, 0, 0, 5'd0, 32'h0, 0, "idle");
  endtask

  task automatic do_reset();
    reset = 1;
    chipselect = 0; write = 0; read = 0; frame_start = 0;
    @(posedge clk);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;
  endtask

  initial begin
    model_clear();
    do_reset();

    // Reset state
    rd_op(5'd0, "rst_rd_entry0");
    rd_op(5'd20, "rst_rd_ctrl");
    rd_op(5'd21, "rst_rd_status");
    check("rst_gl_output", gl_output, 512'h0);

    // Shadow write without commit stays invisible
    wr_op(5'd3, 32'h00ABCDE1, 0);
    fs_op();
    check("no_commit_entry3", {488'h0, gl_output[95:72]}, 512'h0);
    rd_op(5'd3, "rd_entry3");

    // Explicit commit
    wr_op(5'd20, 32'h1, 0);
    rd_op(5'd20, "rd_ctrl_pending");
    fs_op();
    check("commit_entry3", {488'h0, gl_output[95:72]}, {488'h0, 24'hABCDE1});
    idle_op();
    rd_op(5'd20, "rd_ctrl_after");

    // Commit request together with frame_start commits at that edge
    wr_op(5'd20, 32'h1, 1);
    // Armed, then entry write in the commit cycle: active gets old value
    wr_op(5'd20, 32'h1, 0);
    wr_op(5'd20, 32'h1, 0);
    wr_op(5'd0, 32'h00000011, 1);
    check("commit_prewrite_e0", {488'h0, gl_output[23:0]}, 512'h0);
    wr_op(5'd20, 32'h1, 1);
    check("commit_new_e0", {488'h0, gl_output[23:0]}, {488'h0, 24'h000011});

    // Auto-commit
    wr_op(5'd20, 32'h2, 0);
    wr_op(5'd19, 32'h00FFFFF5, 0);
    for (int k = 0; k < 3; k++) begin
      fs_op();
      idle_op();
    end
    check("auto_entry19", {488'h0, gl_output[479:456]}, {488'h0, 24'hFFFFF5});
    check("upper_bits_zero", {480'h0, gl_output[511:480]}, 512'h0);
    wr_op(5'd20, 32'h0, 0);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      logic [4:0] a;
      logic [31:0] d;
      bit w, r, f;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 7) == 0);
      op(($urandom_range(0, 5) != 0), w, r, a, d, f, "rand_rd");
    end

    // Frame counter wrap
    do_reset();
    for (int k = 0; k < 65536; k++) fs_op();
    rd_op(5'd21, "status_wrap");

    // Reset while armed discards the commit
    wr_op(5'd1, 32'h00123456, 0);
    wr_op(5'd20, 32'h1, 0);
    do_reset();
    fs_op();
    idle_op();
    check("armed_reset_out", gl_output, 512'h0);
    rd_op(5'd1, "armed_reset_e1");
    rd_op(5'd20, "armed_reset_ctrl");
    rd_op(5'd21, "armed_reset_status");

    idle_op();
    idle_op();
    idle_op();
    check("rd_queue_drained", 512'(rd_q.size()), 512'h0);
    check("gl_queue_drained", 512'(gl_q.size()), 512'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
